alu_arbiter: RTL

- Shares the single combinational ALU between two requesters, e.g. req0 = execute stage and req1 = address/branch-target unit.
- Round-robin arbitration with a valid/ready handshake on each request port.
- One operand stage register drives the ALU inputs; its result is returned on a shared response channel tagged with the requester id.
- Sits between the pipeline control logic and the ALU instance.

---
 rtl/alu_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters via a single operand stage.
// Optional ALU_ARB_PERF_EN adds grant and stall counters.
module alu_arbiter #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req0_neg,
    input  logic [XLEN-1:0]   req0_a,
    input  logic [XLEN-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic              req1_neg,
    input  logic [XLEN-1:0]   req1_a,
    input  logic [XLEN-1:0]   req1_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              alu_neg,
    output logic [XLEN-1:0]   alu_d1,
    output logic [XLEN-1:0]   alu_d2,
    input  logic [XLEN-1:0]   alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [XLEN-1:0]   rsp_data
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]       perf_grant0,
    output logic [31:0]       perf_grant1,
    output logic [31:0]       perf_stall
`endif
);

    logic              stage_valid;
    logic              stage_id;
    logic [CTRL_W-1:0] stage_ctrl;
    logic              stage_neg;
    logic [XLEN-1:0]   stage_a;
    logic [XLEN-1:0]   stage_b;
    logic              last_grant;

    logic rsp_fire;
    logic can_accept;
    logic grant_any;
    logic grant_id;
    logic accept;

    assign rsp_fire   = stage_valid & rsp_ready;
    assign can_accept = !stage_valid | rsp_fire;
    assign grant_any  = req0_valid | req1_valid;

    // With both requesting, the one not served last wins.
    always_comb begin
        grant_id = req1_valid;
        if (req0_valid && req1_valid)
            grant_id = !last_grant;
    end

    assign req0_ready = can_accept & grant_any & !grant_id;
    assign req1_ready = can_accept & grant_any & grant_id;
    assign accept     = can_accept & grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_id    <= 1'b0;
            stage_ctrl  <= '0;
            stage_neg   <= 1'b0;
            stage_a     <= '0;
            stage_b     <= '0;
            last_grant  <= 1'b1;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_id    <= grant_id;
            last_grant  <= grant_id;
            stage_ctrl  <= grant_id ? req1_ctrl : req0_ctrl;
            stage_neg   <= grant_id ? req1_neg  : req0_neg;
            stage_a     <= grant_id ? req1_a    : req0_a;
            stage_b     <= grant_id ? req1_b    : req0_b;
        end else if (rsp_fire) begin
            stage_valid <= 1'b0;
        end
    end

    assign alu_ctrl  = stage_ctrl;
    assign alu_neg   = stage_neg;
    assign alu_d1    = stage_a;
    assign alu_d2    = stage_b;
    assign rsp_valid = stage_valid;
    assign rsp_id    = stage_id;
    assign rsp_data  = alu_result;

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept && !grant_id)
                perf_grant0 <= perf_grant0 + 32'd1;
            if (accept && grant_id)
                perf_grant1 <= perf_grant1 + 32'd1;
            if (stage_valid && !rsp_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
